param_alu: RTL and testbench
============================

PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter: W, default 8, operand width in bits (legal range 4..32).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: in_valid  in  1  request present on a, b, op, fsel.
REQ-005 Port: in_ready  out  1  block can accept a request; equals (state==IDLE) AND rst_n.
REQ-006 Port: a, b  in  W each  unsigned operands.
REQ-007 Port: op  in  3  000 add, 001 sub, 010 shr1, 011 shl1, 100 and, 101 or, 110 xor, 111 mul.
REQ-008 Port: fsel  in  2  flag select: 00 a>b, 01 a==b, 10 a==0, 11 a even.
REQ-009 Port: out_valid  out  1  result, flag and ovf are valid.
REQ-010 Port: out_ready  in  1  consumer accepts the result.
REQ-011 Port: result  out  2W  operation result.
REQ-012 Port: flag  out  1  comparison flag selected by the captured fsel.
REQ-013 Port: ovf  out  1  high when result[2W-1:W] is nonzero.
REQ-014 Port: busy  out  1  high when state!=IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, MUL and DONE; no other states.
REQ-016 Acceptance occurs on a rising edge where in_valid=1 and in_ready=1; a, b, op and fsel SHALL be captured into internal registers on that edge (edge E).
REQ-017 On acceptance, ops 000-110 go to EXEC; op 111 goes to MUL with an iteration counter cleared to 0.
REQ-018 EXEC: the result is computed from the captured operands and registered at edge E+1; state goes to DONE with out_valid=1 (latency 1).
REQ-019 MUL: a shift-add iteration (one multiplier bit per cycle, LSB first) at each edge E+1..E+W; on edge E+W the full product is registered, state goes to DONE, and out_valid=1 (latency W).
REQ-020 DONE: result, flag, ovf and out_valid are held stable until an edge with out_ready=1; that edge clears out_valid and returns to IDLE.
REQ-021 in_ready is low in EXEC, MUL and DONE; in_valid in those states is ignored and causes no capture.
REQ-022 Only one request is in flight at a time; a new acceptance is earliest on the edge after the DONE->IDLE edge.
REQ-023 Width rules: add result is the zero-extended (W+1)-bit sum.
REQ-024 Width rules: sub result is (a-b) mod 2^(2W).
REQ-025 Width rules: shr1 result is {0,a[W-1:1]} and shl1 result is {a[W-2:0],0}, each zero-extended; and/or/xor results are zero-extended.
REQ-026 Width rules: mul result is the full 2W-bit unsigned product.
REQ-027 flag SHALL be computed from the captured operands and fsel, and registered together with result; comparisons are unsigned.
REQ-028 ovf SHALL be registered together with result and equal the OR of result[2W-1:W].

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, result=0, flag=0, ovf=0, out_valid=0, the counter to 0, and the captured registers to 0.
REQ-030 Reset asserted during MUL or DONE discards the operation; no out_valid for it appears after release.
REQ-031 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.

Configuration
REQ-032 Macro PARAM_ALU_MUL_EN defined: op 111 performs the sequential multiply per REQ-019.
REQ-033 Macro PARAM_ALU_MUL_EN undefined: the MUL state, counter and product datapath are absent; op 111 takes the EXEC path with result=0 and ovf=0, latency 1, and flag computed normally.

Verification (W=8 unless stated)
REQ-034 Scenario: add a=200, b=100, fsel=00 -> one cycle after acceptance out_valid=1, result=0x012C, ovf=1, flag=1.
REQ-035 Scenario: mul a=0xFF, b=0xFF with the macro defined -> out_valid exactly 8 cycles after acceptance, result=0xFE01, ovf=1; in_ready=0 and busy=1 throughout.
REQ-036 Scenario: sub a=5, b=7, fsel=01 -> result=0xFFFE, ovf=1, flag=0.
REQ-037 Scenario: hold out_ready=0 for 5 cycles while in_valid=1 with new operands -> result/flag/ovf/out_valid stay stable, no capture occurs, and IDLE is reached on the edge where out_ready=1.
REQ-038 Scenario: pulse rst_n low on the 3rd cycle of a mul -> out_valid, result and busy go to 0 immediately; after release, add a=1, b=1 returns result=0x0002.
REQ-039 Scenario: W=16, shl1 a=0x8001 -> result=0x00000002, ovf=0; with the macro undefined, op 111 a=3, b=3 -> result=0 after 1 cycle.

Source files
------------

// File: rtl/param_alu.sv
// Small ALU with a valid/ready request and result handshake. W-bit operands, 2W-bit result.
// Define PARAM_ALU_MUL_EN to enable the sequential shift-add multiplier for op 111.
module param_alu #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2:0]     op,
  input  logic [1:0]     fsel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           flag,
  output logic           ovf,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
`ifdef PARAM_ALU_MUL_EN
    MUL,
`endif
    DONE
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2:0]     op_q;
  logic [1:0]     fsel_q;
  logic [2*W-1:0] alu_res;
  logic           flag_c;

  assign in_ready = (state == IDLE) && rst_n;
  assign busy     = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OP_ADD:  alu_res = {{(W-1){1'b0}}, {1'b0, a_q} + {1'b0, b_q}};
      OP_SUB:  alu_res = {{W{1'b0}}, a_q} - {{W{1'b0}}, b_q};
      OP_SHR:  alu_res = {{W{1'b0}}, 1'b0, a_q[W-1:1]};
      OP_SHL:  alu_res = {{W{1'b0}}, a_q[W-2:0], 1'b0};
      OP_AND:  alu_res = {{W{1'b0}}, a_q & b_q};
      OP_OR:   alu_res = {{W{1'b0}}, a_q | b_q};
      OP_XOR:  alu_res = {{W{1'b0}}, a_q ^ b_q};
      default: alu_res = '0;  // multiply is handled by the MUL state, or disabled
    endcase
  end

  always_comb begin
    flag_c = 1'b0;
    unique case (fsel_q)
      2'b00: flag_c = (a_q > b_q);
      2'b01: flag_c = (a_q == b_q);
      2'b10: flag_c = (a_q == '0);
      2'b11: flag_c = ~a_q[0];
    endcase
  end

`ifdef PARAM_ALU_MUL_EN
  localparam int CW = $clog2(W);

  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;

  // One multiplier bit per cycle, LSB first; the partial product is a shifted by the bit index.
  always_comb begin
    acc_next = acc;
    if (b_q[cnt]) acc_next = acc + ({{W{1'b0}}, a_q} << cnt);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  // NOTE: every register, including the captured operands, is cleared by reset so a discarded
  // operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      fsel_q    <= '0;
      result    <= '0;
      flag      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
`ifdef PARAM_ALU_MUL_EN
      cnt       <= '0;
      acc       <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op;
            fsel_q <= fsel;
`ifdef PARAM_ALU_MUL_EN
            if (op == OP_MUL) begin
              cnt   <= '0;
              acc   <= '0;
              state <= MUL;
            end else begin
              state <= EXEC;
            end
`else
            state  <= EXEC;
`endif
          end
        end
        EXEC: begin
          result    <= alu_res;
          ovf       <= |alu_res[2*W-1:W];
          flag      <= flag_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
`ifdef PARAM_ALU_MUL_EN
        MUL: begin
          if (cnt == CW'(W-1)) begin
            result    <= acc_next;
            ovf       <= |acc_next[2*W-1:W];
            flag      <= flag_c;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu: W=8 instance for the main scenarios, W=16 instance for width checks.
// Expectations for op 111 follow PARAM_ALU_MUL_EN.
module tb_param_alu;

  localparam int W = 8;
`ifdef PARAM_ALU_MUL_EN
  localparam int          MUL_LAT   = W;
  localparam logic [15:0] MUL_RES   = 16'hFE01;
  localparam logic        MUL_OVF   = 1'b1;
  localparam int          MUL16_LAT = 16;
  localparam logic [31:0] MUL16_RES = 32'd9;
`else
  localparam int          MUL_LAT   = 1;
  localparam logic [15:0] MUL_RES   = 16'h0000;
  localparam logic        MUL_OVF   = 1'b0;
  localparam int          MUL16_LAT = 1;
  localparam logic [31:0] MUL16_RES = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]   a = '0, b = '0;
  logic [2:0]     op = '0;
  logic [1:0]     fsel = '0;
  logic           in_ready, out_valid, flag, ovf, busy;
  logic [2*W-1:0] result;

  logic           in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0]    a16 = '0, b16 = '0;
  logic [2:0]     op16 = '0;
  logic [1:0]     fsel16 = '0;
  logic           in_ready16, out_valid16, flag16, ovf16, busy16;
  logic [31:0]    result16;

  int checks = 0;
  int failures = 0;

  param_alu #(.W(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .fsel(fsel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag(flag), .ovf(ovf), .busy(busy)
  );

  param_alu #(.W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .fsel(fsel16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .flag(flag16), .ovf(ovf16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] top,
                      input logic [1:0] tf);
    @(negedge clk);
    a = ta; b = tb_; op = top; fsel = tf; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid; bounded so a dead DUT still reaches the summary.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [2:0] top, input logic [1:0] tf, input int exp_lat,
                        input logic [15:0] exp_res, input logic exp_flag, input logic exp_ovf);
    int lat;
    send(ta, tb_, top, tf);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_flag"}, 64'(flag), 64'(exp_flag));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    release_result(tag);
  endtask

  task automatic run_op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic [2:0] top, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_flag, input logic exp_ovf);
    int lat;
    @(negedge clk);
    a16 = ta; b16 = tb_; op16 = top; fsel16 = 2'b00; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
    lat = 0;
    while (out_valid16 !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(result16), 64'(exp_res));
    check({tag, "_flag"}, 64'(flag16), 64'(exp_flag));
    check({tag, "_ovf"}, 64'(ovf16), 64'(exp_ovf));
    @(negedge clk);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1 out_ready16 = 1'b0;
    check({tag, "_valid_clr"}, 64'(out_valid16), 64'd0);
  endtask

  initial begin
    int lat;
    int bad;
    logic [15:0] held_res;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors: tag, a, b, op, fsel, latency, result, flag, ovf
    run_op("add",   8'd200, 8'd100, 3'b000, 2'b00, 1, 16'h012C, 1'b1, 1'b1);
    run_op("sub",   8'd5,   8'd7,   3'b001, 2'b01, 1, 16'hFFFE, 1'b0, 1'b1);
    run_op("shr1",  8'h81,  8'h00,  3'b010, 2'b10, 1, 16'h0040, 1'b0, 1'b0);
    run_op("shl1",  8'h81,  8'h00,  3'b011, 2'b11, 1, 16'h0002, 1'b0, 1'b0);
    run_op("shl1e", 8'h40,  8'h00,  3'b011, 2'b11, 1, 16'h0080, 1'b1, 1'b0);
    run_op("or",    8'h00,  8'h0F,  3'b101, 2'b10, 1, 16'h000F, 1'b1, 1'b0);
    run_op("xor",   8'h5A,  8'h5A,  3'b110, 2'b01, 1, 16'h0000, 1'b1, 1'b0);

    // Multiply: in_ready low and busy high on every cycle before the result
    send(8'hFF, 8'hFF, 3'b111, 2'b11);
    bad = 0;
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      @(posedge clk);
      #1 if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) bad++;
    end
    check("mul_busy_cycles", 64'(bad), 64'd0);
    wait_done(lat);
    check("mul_lat", 64'(lat + MUL_LAT - 1), 64'(MUL_LAT));
    check("mul_res", 64'(result), 64'(MUL_RES));
    check("mul_ovf", 64'(ovf), 64'(MUL_OVF));
    check("mul_flag", 64'(flag), 64'd0);
    release_result("mul");

    // Stall: out_ready held low with a competing request on the inputs
    send(8'hF0, 8'h3C, 3'b100, 2'b00);
    wait_done(lat);
    check("and_res", 64'(result), 64'h30);
    check("and_flag", 64'(flag), 64'd1);
    held_res = result;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'h11; b = 8'h22; op = 3'b000; fsel = 2'b01;
      #1 if (result !== held_res || flag !== 1'b1 || ovf !== 1'b0 ||
             out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("stall_stable", 64'(bad), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    check("stall_valid_clr", 64'(out_valid), 64'd0);
    check("stall_idle", 64'(busy), 64'd0);

    // Reset pulse in the third cycle of a multiply
    send(8'hFF, 8'hFF, 3'b111, 2'b00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_rel_ready", 64'(in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst_discard", 64'(bad), 64'd0);
    run_op("add_post_rst", 8'd1, 8'd1, 3'b000, 2'b01, 1, 16'h0002, 1'b1, 1'b0);

    // W=16 instance
    run_op16("w16_shl1", 16'h8001, 16'h0000, 3'b011, 1, 32'h00000002, 1'b1, 1'b0);
    run_op16("w16_mul", 16'd3, 16'd3, 3'b111, MUL16_LAT, MUL16_RES, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
